alu_accumulator: RTL and testbench

//  Datapath stage directly downstream of the 6-bit control-state sequencer; consumes its state code each cycle.

---
 rtl/alu_accumulator.sv | 119 +++++++++++
 tb/tb_alu_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator.sv
// Accumulator/operand datapath slaved to the control-state sequencer: load, add, and a
// WIDTH-cycle shift-add multiply that stalls the sequencer. Optional flags under ALU_FLAGS_EN.
module alu_accumulator #(
    parameter int         WIDTH   = 16,
    parameter logic [5:0] ST_LDAC = 6'd10,
    parameter logic [5:0] ST_LDR  = 6'd14,
    parameter logic [5:0] ST_ADD  = 6'd19,
    parameter logic [5:0] ST_MUL  = 6'd21,
    parameter logic [5:0] ST_CLR  = 6'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       state,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] ac_out,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             zero,
    output logic             carry
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {MUL_IDLE, MUL_RUN} mul_state_e;

    mul_state_e         mst, mst_nxt;
    logic [5:0]         prev_state;
    logic [WIDTH-1:0]   ac, r;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] product, prod_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic               mul_start, mul_last, idle_op;

    // Edge-detect on ST_MUL so a sequencer holding the code during stall cannot retrigger.
    assign mul_start = (state == ST_MUL) && (prev_state != ST_MUL) && (mst == MUL_IDLE);
    assign idle_op   = (mst == MUL_IDLE) && !mul_start;
    assign busy      = (mst == MUL_RUN);
    assign stall     = busy | mul_start;
    assign ac_out    = ac;
    assign sum       = {1'b0, ac} + {1'b0, r};
    assign prod_nxt  = product + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);

    always_comb begin
        mst_nxt  = mst;
        mul_last = 1'b0;
        case (mst)
            MUL_IDLE: if (mul_start) mst_nxt = MUL_RUN;
            MUL_RUN: begin
                if (cnt == LAST) begin
                    mul_last = 1'b1;
                    mst_nxt  = MUL_IDLE;
                end
            end
            default: mst_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mst        <= MUL_IDLE;
            prev_state <= ST_CLR;
            ac         <= '0;
            r          <= '0;
            mcand      <= '0;
            mplier     <= '0;
            product    <= '0;
            cnt        <= '0;
            done       <= 1'b0;
        end else begin
            mst        <= mst_nxt;
            prev_state <= state;
            done       <= mul_last;
            if (mul_start) begin
                mcand   <= ac;
                mplier  <= r;
                product <= '0;
                cnt     <= '0;
            end else if (busy) begin
                product <= prod_nxt;
                mplier  <= mplier >> 1;
                cnt     <= cnt + CW'(1);
                if (mul_last) ac <= prod_nxt[WIDTH-1:0];
            end else begin
                case (state)
                    ST_LDAC: ac <= bus_in;
                    ST_LDR:  r  <= bus_in;
                    ST_ADD:  ac <= sum[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic carry_q;

    always_ff @(posedge clock) begin
        if (reset)
            carry_q <= 1'b0;
        else if (idle_op && state == ST_ADD)
            carry_q <= sum[WIDTH];
        else if (mul_last)
            carry_q <= |prod_nxt[2*WIDTH-1:WIDTH];
    end

    assign carry = carry_q;
    assign zero  = (ac == '0);
`else
    logic unused_flags;

    assign unused_flags = sum[WIDTH] ^ (|prod_nxt[2*WIDTH-1:WIDTH]) ^ idle_op;
    assign carry        = 1'b0;
    assign zero         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_accumulator.sv
// Randomized self-checking bench for alu_accumulator against a plain-arithmetic model.
module tb_alu_accumulator;
    localparam int W = 16;
    localparam logic [5:0] LDAC = 6'd10, LDR = 6'd14, ADD = 6'd19, MUL = 6'd21, CLR = 6'd0;
`ifdef ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [5:0]   state = CLR;
    logic [W-1:0] bus_in = '0;
    logic [W-1:0] ac_out;
    logic         busy, done, stall, zero, carry;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] ac_m = '0, r_m = '0;
    logic         carry_m = 1'b0;

    alu_accumulator #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .state(state), .bus_in(bus_in),
        .ac_out(ac_out), .busy(busy), .done(done), .stall(stall),
        .zero(zero), .carry(carry)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [5:0] st, input logic [W-1:0] v, input string nm);
        longint unsigned s;
        logic exp_c, exp_z;
        state = st; bus_in = v;
        tick();
        if (st == LDAC) ac_m = v;
        else if (st == LDR) r_m = v;
        else if (st == ADD) begin
            s = longint'(ac_m) + longint'(r_m);
            carry_m = (s >> W) != 0;
            ac_m = W'(s);
        end
        state = CLR;
        exp_c = FLAGS ? carry_m : 1'b0;
        exp_z = FLAGS ? (ac_m == 0) : 1'b0;
        checks++;
        if (ac_out !== ac_m) begin
            errors++; $display("FAIL %s ac_out got %h want %h", nm, ac_out, ac_m);
        end
        checks++;
        if (carry !== exp_c) begin
            errors++; $display("FAIL %s carry got %b want %b", nm, carry, exp_c);
        end
        checks++;
        if (zero !== exp_z) begin
            errors++; $display("FAIL %s zero got %b want %b", nm, zero, exp_z);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; state = CLR;
        tick(); tick();
        ac_m = '0; r_m = '0; carry_m = 1'b0;
        checks++;
        if (ac_out !== '0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset ac/busy/done/stall got %h/%b/%b/%b want 0/0/0/0", ac_out, busy, done, stall);
        end
        checks++;
        if (zero !== FLAGS || carry !== 1'b0) begin
            errors++; $display("FAIL reset zero/carry got %b/%b want %b/0", zero, carry, FLAGS);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        do_op(LDAC, 16'h0005, "add_ldac");
        do_op(LDR,  16'h0003, "add_ldr");
        do_op(ADD,  '0,       "add_5p3");
        checks++;
        if (ac_out !== 16'h0008) begin
            errors++; $display("FAIL add_const got %h want 0008", ac_out);
        end
    endtask

    task automatic test_add_wrap();
        do_op(LDAC, 16'hFFFF, "wrap_ldac");
        do_op(LDR,  16'h0002, "wrap_ldr");
        do_op(ADD,  '0,       "wrap_add");
        checks++;
        if (ac_out !== 16'h0001 || carry !== FLAGS) begin
            errors++; $display("FAIL add_wrap got %h/%b want 0001/%b", ac_out, carry, FLAGS);
        end
    endtask

    // hold=1: sequencer keeps ST_MUL; hold=0: drive LDAC junk while busy
    task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                            input logic [W-1:0] junk, input string nm);
        longint unsigned p;
        int busy_cnt, done_cnt;
        logic [W-1:0] exp_ac;
        do_op(LDAC, a, "mul_lda");
        do_op(LDR,  b, "mul_ldr");
        p = longint'(a) * longint'(b);
        exp_ac = W'(p);
        state = MUL;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL %s stall_at_start got %b want 1", nm, stall);
        end
        tick();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                checks++;
                if (i != W || ac_out !== exp_ac || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_result at %0d got %h busy %b want %0d %h busy 0", nm, i, ac_out, busy, W, exp_ac);
                end
            end else if (busy) begin
                checks++;
                if (ac_out !== a || stall !== 1'b1) begin
                    errors++; $display("FAIL %s during_busy ac/stall got %h/%b want %h/1", nm, ac_out, stall, a);
                end
            end
            if (hold) state = MUL;
            else begin
                state = busy ? LDAC : CLR;
                bus_in = junk;
            end
            tick();
        end
        ac_m = exp_ac;
        carry_m = (p >> W) != 0;
        checks++;
        if (busy_cnt != W || done_cnt != 1) begin
            errors++; $display("FAIL %s busy_cycles/done_pulses got %0d/%0d want %0d/1", nm, busy_cnt, done_cnt, W);
        end
        checks++;
        if (ac_out !== ac_m || carry !== (FLAGS ? carry_m : 1'b0)) begin
            errors++; $display("FAIL %s final ac/carry got %h/%b want %h/%b", nm, ac_out, carry, ac_m, FLAGS ? carry_m : 1'b0);
        end
        state = CLR;
        tick();
    endtask

    task automatic test_mul_reset_abort();
        int done_seen;
        do_op(LDAC, 16'h0123, "abort_lda");
        do_op(LDR,  16'h0045, "abort_ldr");
        state = MUL;
        tick();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; state = CLR;
        ac_m = '0; r_m = '0; carry_m = 1'b0;
        checks++;
        if (busy !== 1'b0 || ac_out !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL abort busy/ac/done got %b/%h/%b want 0/0000/0", busy, ac_out, done);
        end
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen != 0 || ac_out !== '0) begin
            errors++; $display("FAIL abort_quiet activity %0d ac %h want 0 0000", done_seen, ac_out);
        end
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: do_op(LDAC, W'($urandom), "rnd_ldac");
                3, 4, 5: do_op(LDR,  W'($urandom), "rnd_ldr");
                6, 7:    do_op(ADD,  W'($urandom), "rnd_add");
                8:       do_op(CLR,  W'($urandom), "rnd_clr");
                default: test_mul(W'($urandom), W'($urandom), 1'($urandom), W'($urandom), "rnd_mul");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_wrap();
        test_mul(16'h0007, 16'h0006, 1'b1, '0, "mul_7x6");
        test_mul(16'h1234, 16'h0100, 1'b0, 16'hAAAA, "mul_ignore_ld");
        test_mul_reset_abort();
        test_mul(16'h0007, 16'h0006, 1'b1, '0, "mul_after_abort");
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
